// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle execute controller: ALU ops via external alu, shifts done serially (ALU_SEQ_SHIFT4_EN enables 4-bit shift steps)
module alu_sequencer #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [XLEN-1:0]  reqOpA,
    input  logic [XLEN-1:0]  reqOpB,
    input  logic [3:0]       reqSel,
    input  logic [TAG_W-1:0] reqTag,
    output logic             rspValid,
    input  logic             rspReady,
    output logic [XLEN-1:0]  rspResult,
    output logic [TAG_W-1:0] rspTag,
    output logic             rspErr,
    output logic             busy,
    output logic [XLEN-1:0]  aluOpA,
    output logic [XLEN-1:0]  aluOpB,
    output logic [3:0]       aluOutSel,
    input  logic [XLEN-1:0]  aluOut
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SHIFT,
        RESP
    } state_t;

    localparam logic [3:0] SEL_SLTU = 4'b0110;
    localparam logic [3:0] SEL_SLL  = 4'b0111;
    localparam logic [3:0] SEL_SRL  = 4'b1000;
    localparam logic [3:0] SEL_SRA  = 4'b1001;
    localparam logic [3:0] SEL_PASS = 4'b1111;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [3:0]        sel_q, sel_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   shreg_q, shreg_d;
    logic [4:0]        cnt_q, cnt_d;

    logic              req_is_alu;
    logic              req_is_shift;
    logic [4:0]        req_shamt;
    logic [4:0]        step;
    logic [XLEN-1:0]   shifted;

    assign req_is_alu   = (reqSel <= SEL_SLTU) || (reqSel == SEL_PASS);
    assign req_is_shift = (reqSel == SEL_SLL) || (reqSel == SEL_SRL) || (reqSel == SEL_SRA);
    assign req_shamt    = reqOpB[4:0];

    // Distance moved by one SHIFT cycle and the resulting shift-register value
    always_comb begin
        step    = 5'd1;
        shifted = shreg_q;
`ifdef ALU_SEQ_SHIFT4_EN
        if (cnt_q >= 5'd4) begin
            step = 5'd4;
        end
`else
        step = 5'd1;
`endif
        case (sel_q)
            SEL_SLL: shifted = shreg_q << step;
            SEL_SRA: shifted = $unsigned($signed(shreg_q) >>> step);
            default: shifted = shreg_q >> step;
        endcase
    end

    // Next-state and datapath-register update logic
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sel_d    = sel_q;
        tag_d    = tag_q;
        result_d = result_q;
        err_d    = err_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    opa_d = reqOpA;
                    opb_d = reqOpB;
                    sel_d = reqSel;
                    tag_d = reqTag;
                    err_d = 1'b0;
                    if (req_is_alu) begin
                        state_d = EXEC;
                    end else if (req_is_shift) begin
                        if (req_shamt == 5'd0) begin
                            result_d = reqOpA;
                            state_d  = RESP;
                        end else begin
                            shreg_d = reqOpA;
                            cnt_d   = req_shamt;
                            state_d = SHIFT;
                        end
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            EXEC: begin
                result_d = aluOut;
                state_d  = RESP;
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - step;
                if (cnt_q == step) begin
                    result_d = shifted;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and holding registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            sel_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            shreg_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sel_q    <= sel_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            err_q    <= err_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign reqReady  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rspValid  = (state_q == RESP);
    assign rspResult = result_q;
    assign rspTag    = tag_q;
    assign rspErr    = err_q;
    assign aluOpA    = opa_q;
    assign aluOpB    = opb_q;
    assign aluOutSel = sel_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a behavioural alu
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqOpA;
    logic [31:0] reqOpB;
    logic [3:0]  reqSel;
    logic [3:0]  reqTag;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspResult;
    logic [3:0]  rspTag;
    logic        rspErr;
    logic        busy;
    logic [31:0] aluOpA;
    logic [31:0] aluOpB;
    logic [3:0]  aluOutSel;
    logic [31:0] aluOut;

    int n_pass;
    int n_total;
    int cyc;

    alu_sequencer #(.XLEN(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqOpA    (reqOpA),
        .reqOpB    (reqOpB),
        .reqSel    (reqSel),
        .reqTag    (reqTag),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .rspResult (rspResult),
        .rspTag    (rspTag),
        .rspErr    (rspErr),
        .busy      (busy),
        .aluOpA    (aluOpA),
        .aluOpB    (aluOpB),
        .aluOutSel (aluOutSel),
        .aluOut    (aluOut)
    );

    // External ALU; shift selects return a marker so misuse shows up in results
    always_comb begin
        aluOut = 32'hDEAD_BEEF;
        case (aluOutSel)
            4'b0000: aluOut = aluOpA + aluOpB;
            4'b0001: aluOut = aluOpA - aluOpB;
            4'b0010: aluOut = aluOpA ^ aluOpB;
            4'b0011: aluOut = aluOpA | aluOpB;
            4'b0100: aluOut = aluOpA & aluOpB;
            4'b0101: aluOut = {31'b0, ($signed(aluOpA) < $signed(aluOpB))};
            4'b0110: aluOut = {31'b0, (aluOpA < aluOpB)};
            4'b1111: aluOut = aluOpA;
            default: aluOut = 32'hDEAD_BEEF;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int shift_lat(input int n);
`ifdef ALU_SEQ_SHIFT4_EN
        return (n / 4) + (n % 4) + 1;
`else
        return n + 1;
`endif
    endfunction

    // Issue one request with rspReady high, check latency/result/tag/err, complete handshake
    task automatic do_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp_res,
                         input logic exp_err, input int exp_lat);
        int lat;
        check({name, "_ready"}, {31'b0, reqReady}, 32'd1);
        reqValid = 1'b1;
        reqOpA   = a;
        reqOpB   = b;
        reqSel   = sel;
        reqTag   = tag;
        rspReady = 1'b1;
        tick();
        reqValid = 1'b0;
        if (exp_lat == 2) begin
            check({name, "_exec_sel"}, {28'b0, aluOutSel}, {28'b0, sel});
            check({name, "_exec_busy"}, {31'b0, busy}, 32'd1);
        end
        lat = 1;
        while (rspValid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        check({name, "_valid"}, {31'b0, rspValid}, 32'd1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, rspResult, exp_res);
        check({name, "_tag"}, {28'b0, rspTag}, {28'b0, tag});
        check({name, "_err"}, {31'b0, rspErr}, {31'b0, exp_err});
        tick();
    endtask

    initial begin
        int t_prev;
        int lat;
        n_pass   = 0;
        n_total  = 0;
        cyc      = 0;
        rst      = 1'b1;
        reqValid = 1'b1;
        reqOpA   = 32'd9;
        reqOpB   = 32'd9;
        reqSel   = 4'b0000;
        reqTag   = 4'd9;
        rspReady = 1'b0;

        // Reset with a simultaneous request: nothing accepted, all outputs zero
        tick();
        tick();
        check("rst_ready", {31'b0, reqReady}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rspvalid", {31'b0, rspValid}, 32'd0);
        check("rst_result", rspResult, 32'd0);
        check("rst_tag", {28'b0, rspTag}, 32'd0);
        check("rst_err", {31'b0, rspErr}, 32'd0);
        check("rst_aluopa", aluOpA, 32'd0);
        check("rst_aluopb", aluOpB, 32'd0);
        check("rst_alusel", {28'b0, aluOutSel}, 32'd0);
        rst      = 1'b0;
        reqValid = 1'b0;
        tick();

        // ALU ops
        do_op("add", 4'b0000, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 2);
        do_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd1, 1'b0, 2);
        do_op("sltu", 4'b0110, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd0, 1'b0, 2);
        do_op("sub_wrap", 4'b0001, 32'd0, 32'd1, 4'd6, 32'hFFFF_FFFF, 1'b0, 2);
        do_op("pass", 4'b1111, 32'h1234_5678, 32'd0, 4'd7, 32'h1234_5678, 1'b0, 2);

        // Shifts
        do_op("sra31", 4'b1001, 32'h8000_0000, 32'd31, 4'd8, 32'hFFFF_FFFF, 1'b0, shift_lat(31));
        do_op("sll0", 4'b0111, 32'd1, 32'd0, 4'd9, 32'd1, 1'b0, 1);
        do_op("sll5", 4'b0111, 32'd1, 32'h0000_0025, 4'd10, 32'h0000_0020, 1'b0, shift_lat(5));
        do_op("srl4", 4'b1000, 32'hF000_0000, 32'd4, 4'd11, 32'h0F00_0000, 1'b0, shift_lat(4));
        do_op("sra6", 4'b1001, 32'h4000_0000, 32'd6, 4'd12, 32'h0100_0000, 1'b0, shift_lat(6));

        // Illegal op with consumer stalled for 5 cycles
        reqValid = 1'b1;
        reqOpA   = 32'hAAAA_AAAA;
        reqOpB   = 32'h5555_5555;
        reqSel   = 4'b1100;
        reqTag   = 4'd13;
        rspReady = 1'b0;
        tick();
        reqValid = 1'b0;
        check("ill_latency", {31'b0, rspValid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ill_hold_valid", {31'b0, rspValid}, 32'd1);
            check("ill_hold_result", rspResult, 32'd0);
            check("ill_hold_err", {31'b0, rspErr}, 32'd1);
            check("ill_hold_tag", {28'b0, rspTag}, 32'd13);
            check("ill_hold_ready", {31'b0, reqReady}, 32'd0);
        end
        rspReady = 1'b1;
        tick();
        check("ill_release_ready", {31'b0, reqReady}, 32'd1);
        check("ill_release_valid", {31'b0, rspValid}, 32'd0);

        // Reset during a long shift drops the operation
        reqValid = 1'b1;
        reqOpA   = 32'hF000_0000;
        reqOpB   = 32'd20;
        reqSel   = 4'b1000;
        reqTag   = 4'd14;
        tick();
        reqValid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", {31'b0, reqReady}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_valid", {31'b0, rspValid}, 32'd0);
        repeat (3) tick();
        check("midrst_no_rsp", {31'b0, rspValid}, 32'd0);
        do_op("post_rst_add", 4'b0000, 32'd1, 32'd1, 4'd2, 32'd2, 1'b0, 2);

        // Back-to-back xor with reqValid and rspReady held high
        rspReady = 1'b1;
        reqValid = 1'b1;
        t_prev   = 0;
        for (int i = 0; i < 4; i++) begin
            lat = 0;
            while (reqReady !== 1'b1 && lat < 16) begin
                tick();
                lat++;
            end
            reqOpA = 32'h0000_00F0 + i;
            reqOpB = 32'h0000_0F0F;
            reqSel = 4'b0010;
            reqTag = 4'(i + 1);
            tick();
            lat = 1;
            while (rspValid !== 1'b1 && lat < 16) begin
                tick();
                lat++;
            end
            if (i == 3) reqValid = 1'b0;
            check("b2b_result", rspResult, (32'h0000_00F0 + i) ^ 32'h0000_0F0F);
            check("b2b_tag", {28'b0, rspTag}, i + 1);
            if (i > 0) check("b2b_interval", cyc - t_prev, 32'd3);
            t_prev = cyc;
        end
        tick();
        tick();
        check("b2b_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
